instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch block: owns the fetch PC, issues reads to a fixed-latency instruction memory, realigns returning words with their PCs, and buffers them for decode under backpressure. It consumes the branch redirect produced at write-back (taken-branch flag plus target), discards every in-flight and buffered word on redirect, and restarts fetch at the target. Sits between instruction memory and the decode phase.

## Interface
- LOAD_LATENCY, 1, cycles from imem_req to valid imem_rdata (≥1)
- ADDR_W, 32, PC / address width
- INST_W, 32, instruction word width
- Q_DEPTH, LOAD_LATENCY+2, decode-side buffer depth (≥ LOAD_LATENCY+1; LOAD_LATENCY+2 gives full throughput)
- INIT_PC, 0, fetch PC after reset

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- redirect_valid  in  1  taken branch; kill all fetched/in-flight work
- redirect_pc  in  ADDR_W  branch target, sampled when redirect_valid=1
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address (= fetch PC)
- imem_rdata  in  INST_W  read data, valid exactly LOAD_LATENCY cycles after request
- out_valid  out  1  out_inst/out_pc valid for decode
- out_inst  out  INST_W  instruction word at FIFO head
- out_pc  out  ADDR_W  PC of out_inst
- out_ready  in  1  decode accepts head this cycle

## Operation
- State: fetch PC register; in-flight shift pipe of LOAD_LATENCY entries {valid, pc}; FIFO of Q_DEPTH entries {inst, pc} with read/write pointers and count.
- Credit: occ = fifo_count + in-flight valid count (registered values, no same-cycle pop credit).
- Issue: imem_req = rstn & ~redirect_valid & (occ < Q_DEPTH). imem_addr = PC at all times. On issue, PC <= PC+1 (modulo 2^ADDR_W, word addressing), pipe[0] <= {1, PC}; else pipe[0].valid <= 0. Pipe shifts every cycle, never stalls.
- Return: in cycle where pipe[LOAD_LATENCY-1].valid=1, push {imem_rdata, pipe[LOAD_LATENCY-1].pc} into FIFO.
- Output: out_valid = (fifo_count≠0) & ~redirect_valid; out_inst/out_pc = head entry. Pop when out_valid & out_ready.
- Push and pop in same cycle allowed at any count, including full; credit rule guarantees no overflow — overflow is a design error (assertion in bench).
- Redirect (redirect_valid=1): PC <= redirect_pc; all pipe valid bits cleared; FIFO cleared (count 0, pointers 0); that cycle's return push and pop suppressed; no request issued. Back-to-back redirects: last one wins, req held low throughout.
- Reset: PC=INIT_PC, pipe valid bits 0, FIFO empty, storage 0. Reset dominates redirect.

## Timing
- Reset values: imem_req 0 (gated by rstn), imem_addr INIT_PC after first reset edge, out_valid 0, out_inst 0, out_pc 0.
- First request: first cycle with rstn=1, address INIT_PC.
- Request in cycle t → data pushed at t+LOAD_LATENCY → out_valid at t+LOAD_LATENCY+1 earliest.
- Redirect in cycle r → first request to redirect_pc in r+1 → first out_valid for it in r+LOAD_LATENCY+2.
- out_ready=1 continuously and Q_DEPTH ≥ LOAD_LATENCY+2: one request and one output per cycle steady state.
- out_ready=0: requests stop once occ reaches Q_DEPTH; exactly Q_DEPTH words buffered, none lost; resumption one cycle after pop frees credit.
- Order: out_pc strictly PC+1 sequence between redirects; no duplicates, no gaps.

## Test plan
- LOAD_LATENCY=1, INIT_PC=0, mem[i]=0xA000+i, out_ready=1 → imem_addr 0,1,2… from cycle 0; out_valid from cycle 2, out_pc 0,1,2…, out_inst 0xA000,0xA001…, one per cycle.
- LOAD_LATENCY=2, Q_DEPTH=4, out_ready=0 for 10 cycles from reset → exactly 4 requests (addr 0–3), imem_req 0 afterward; on out_ready=1, outputs pc 0,1,2,3,4… with no loss or repeat.
- LOAD_LATENCY=2, steady fetch, redirect_valid=1 with redirect_pc=0x100 while 2 in flight and 1 buffered → out_valid 0 in redirect cycle, imem_req 0 that cycle, next cycle imem_addr 0x100; next out_pc is 0x100, no stale pc ever emitted.
- FIFO full, out_ready=1, redirect_valid=1 same cycle → no pop counted, FIFO empty next cycle; redirect on two consecutive cycles (0x40 then 0x80) → first fetched out_pc 0x80.
- ADDR_W=8, INIT_PC=0xFE → addresses 0xFE,0xFF,0x00,0x01; out_pc follows the same wrap.
- rstn low for 1 cycle mid-stream with full FIFO → next cycle out_valid 0, imem_addr INIT_PC, in-flight returns discarded, fetch restarts exactly as after power-on.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory port and the
// decode-side output handshake. master = fetch unit, slave = its environment.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues reads to a
// fixed-latency instruction memory, tags returning words with their PC via a
// valid/pc shift pipe, and buffers them in a small FIFO for decode.
// Requests are credit-limited so the FIFO can never overflow; a redirect
// flushes the pipe and the FIFO and restarts fetch at the target.
module instruction_fetch_unit #(
  parameter int                LOAD_LATENCY = 1,
  parameter int                ADDR_W       = 32,
  parameter int                INST_W       = 32,
  parameter int                Q_DEPTH      = LOAD_LATENCY + 2,
  parameter logic [ADDR_W-1:0] INIT_PC      = '0
) (
  input logic                      clk,
  input logic                      rstn,
  instruction_fetch_unit_if.master io_fetch
);

  localparam int STAGES = LOAD_LATENCY - 1;
  localparam int PW     = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int OW     = $clog2(Q_DEPTH + LOAD_LATENCY + 1);
  localparam logic [OW-1:0] QD       = OW'(Q_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(Q_DEPTH - 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  // fetch PC and in-flight tag pipe (stage STAGES lines up with imem_rdata)
  logic [ADDR_W-1:0]             r_pc;
  logic [STAGES:0]               r_vld_pipe;
  logic [STAGES:0][ADDR_W-1:0]   r_pc_pipe;

  // decode-side buffer
  fetch_ent_t [Q_DEPTH-1:0]      r_fifo;
  logic [PW-1:0]                 r_wr;
  logic [PW-1:0]                 r_rd;
  logic [OW-1:0]                 r_count;

  logic [OW-1:0]                 w_inflight;
  logic [OW-1:0]                 w_occ;
  logic                          w_redir;
  logic                          w_issue;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_out_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Count words already requested but not yet written into the FIFO
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= STAGES; i++)
      w_inflight = w_inflight + OW'(r_vld_pipe[i]);
  end

  // Credit uses registered state only: a pop this cycle frees credit next cycle
  assign w_occ       = w_inflight + r_count;
  assign w_redir     = io_fetch.redirect_valid;
  assign w_issue     = rstn & ~w_redir & (w_occ < QD);
  assign w_push      = r_vld_pipe[STAGES] & ~w_redir;
  assign w_out_valid = (r_count != '0) & ~w_redir;
  assign w_pop       = w_out_valid & io_fetch.out_ready;

  assign io_fetch.imem_req  = w_issue;
  assign io_fetch.imem_addr = r_pc;
  assign io_fetch.out_valid = w_out_valid;
  assign io_fetch.out_inst  = r_fifo[r_rd].inst;
  assign io_fetch.out_pc    = r_fifo[r_rd].pc;

  // Advance fetch PC on issue and shift request tags toward the return stage
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc       <= INIT_PC;
      r_vld_pipe <= '0;
      r_pc_pipe  <= '0;
    end else if (w_redir) begin
      r_pc       <= io_fetch.redirect_pc;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_issue;
      r_pc_pipe[0]  <= r_pc;
      if (w_issue)
        r_pc <= r_pc + ADDR_W'(1);
      for (int i = 1; i <= STAGES; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_pc_pipe[i]  <= r_pc_pipe[i-1];
      end
    end
  end

  // Capture returning words with their PC; decode pops from the head
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fifo  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (w_redir) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr].inst <= io_fetch.imem_rdata;
        r_fifo[r_wr].pc   <= r_pc_pipe[STAGES];
        r_wr              <= ptr_inc(r_wr);
      end
      if (w_pop)
        r_rd <= ptr_inc(r_rd);
      r_count <= r_count + OW'(w_push) - OW'(w_pop);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a memory model answers requests after
// LOAD_LATENCY cycles; a queue-based reference model predicts every request,
// its address and when/what each output word must be.
module tb_instruction_fetch_unit;
  localparam int LAT = 2;
  localparam int AW  = 8;
  localparam int IW  = 32;
  localparam int QD  = 4;
  localparam logic [AW-1:0] INIT = 8'hFE;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0, n_tests = 0, n_fail = 0, n_out = 0;

  instruction_fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  instruction_fetch_unit #(
    .LOAD_LATENCY(LAT), .ADDR_W(AW), .INST_W(IW), .Q_DEPTH(QD), .INIT_PC(INIT)
  ) dut (
    .clk(clk), .rstn(rstn), .io_fetch(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
    return IW'(32'hA000) + IW'(a);
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // memory: data for the request of cycle t is presented during cycle t+LAT
  logic          hreq  [LAT];
  logic [AW-1:0] haddr [LAT];
  initial begin
    for (int i = 0; i < LAT; i++) begin hreq[i] = 1'b0; haddr[i] = '0; end
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      for (int i = LAT - 1; i > 0; i--) begin hreq[i] = hreq[i-1]; haddr[i] = haddr[i-1]; end
      hreq[0]  = bus.imem_req;
      haddr[0] = bus.imem_addr;
      @(posedge clk); #1;
      bus.imem_rdata = hreq[LAT-1] ? mem(haddr[LAT-1]) : IW'($urandom);
    end
  end

  // reference model: sb holds every word requested and not yet delivered,
  // with the earliest cycle it may appear at the output
  typedef struct { logic [AW-1:0] pc; int rdy; } exp_t;
  exp_t          sb[$];
  logic [AW-1:0] fpc = INIT;

  always @(negedge clk) begin
    bit exp_req, exp_vld;
    if (!rstn) begin
      check("req_in_reset", 64'(bus.imem_req), 64'(0));
      sb.delete();
      fpc = INIT;
    end else begin
      exp_req = !bus.redirect_valid && (sb.size() < QD);
      exp_vld = !bus.redirect_valid && (sb.size() > 0) && (sb[0].rdy <= cyc);
      check("imem_req", 64'(bus.imem_req), 64'(exp_req));
      if (exp_req) check("imem_addr", 64'(bus.imem_addr), 64'(fpc));
      check("out_valid", 64'(bus.out_valid), 64'(exp_vld));
      if (exp_vld && bus.out_ready) begin
        check("out_pc", 64'(bus.out_pc), 64'(sb[0].pc));
        check("out_inst", 64'(bus.out_inst), 64'(mem(sb[0].pc)));
        void'(sb.pop_front());
        n_out++;
      end
      if (bus.redirect_valid) begin
        sb.delete();
        fpc = bus.redirect_pc;
      end else if (exp_req) begin
        sb.push_back('{pc: fpc, rdy: cyc + LAT + 1});
        fpc = fpc + AW'(1);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    tick(2);
    // reset state after the first reset edges
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_inst",  64'(bus.out_inst),  64'(0));
    check("rst_out_pc",    64'(bus.out_pc),    64'(0));
    check("rst_imem_addr", 64'(bus.imem_addr), 64'(INIT));
    rstn = 1'b1;

    // streaming with address wrap 0xFE,0xFF,0x00...
    tick(20);

    // backpressure: fill to Q_DEPTH, then redirect while full with ready high
    bus.out_ready = 1'b0;
    tick(12);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40;
    tick();
    bus.redirect_pc = 8'h80;
    tick();
    bus.redirect_valid = 1'b0;
    tick(15);

    // single redirect in steady streaming
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h10;
    tick();
    bus.redirect_valid = 1'b0;
    tick(12);

    // backpressure release only
    bus.out_ready = 1'b0;
    tick(10);
    bus.out_ready = 1'b1;
    tick(10);

    // one-cycle reset with a full FIFO and words in flight
    bus.out_ready = 1'b0;
    tick(8);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    tick(15);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = AW'($urandom);
      rstn               = ($urandom_range(0, 99) != 0);
      tick();
    end
    bus.redirect_valid = 1'b0;
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    tick(10);

    // the stream must actually have delivered words
    n_tests++;
    if (n_out < 500) begin
      n_fail++;
      $display("FAIL delivered_words: got %0d required at least 500", n_out);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
